m_dram_arbiter_n: RTL and testbench

Parametrised N-hart DRAM arbiter that lets NHARTS copies of the CPU+MMU core share one DRAM controller port. Each hart keeps its private single-requester DRAM handshake (addr/wdata/we_t/le/ctrl out, odata/busy in). The arbiter latches requests, grants them round-robin, optionally holds the grant for locked (AMO) sequences, and returns read data per hart. It sits between the hart MMUs and the DRAM controller in the multi-hart top level.

---
 rtl/m_dram_arbiter_n_if.sv | 40 ++++
 rtl/m_dram_arbiter_n.sv | 145 ++++++++++++++
 tb/tb_m_dram_arbiter_n.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/m_dram_arbiter_n_if.sv
// Bus bundle between the hart MMU ports, the arbiter and the shared DRAM controller port.
// The arbiter uses the slave view; the multi-hart top (or a bench) drives the master view.
interface m_dram_arbiter_n_if #(
  parameter int NHARTS = 2,
  parameter int AW     = 32,
  parameter int DW     = 32
);
  localparam int GW = (NHARTS > 1) ? $clog2(NHARTS) : 1;

  logic [NHARTS*AW-1:0] w_hart_addr;
  logic [NHARTS*DW-1:0] w_hart_wdata;
  logic [NHARTS-1:0]    w_hart_we_t;
  logic [NHARTS-1:0]    w_hart_le;
  logic [NHARTS*3-1:0]  w_hart_ctrl;
  logic [NHARTS-1:0]    w_hart_lock;
  logic [NHARTS*DW-1:0] w_hart_odata;
  logic [NHARTS-1:0]    w_hart_busy;
  logic [AW-1:0]        w_dram_addr;
  logic [DW-1:0]        w_dram_wdata;
  logic                 w_dram_we_t;
  logic                 w_dram_le;
  logic [2:0]           w_dram_ctrl;
  logic [DW-1:0]        w_dram_odata;
  logic                 w_dram_busy;
  logic [GW-1:0]        w_grant;

  modport slave (
    input  w_hart_addr, w_hart_wdata, w_hart_we_t, w_hart_le, w_hart_ctrl, w_hart_lock,
    input  w_dram_odata, w_dram_busy,
    output w_hart_odata, w_hart_busy,
    output w_dram_addr, w_dram_wdata, w_dram_we_t, w_dram_le, w_dram_ctrl, w_grant
  );

  modport master (
    output w_hart_addr, w_hart_wdata, w_hart_we_t, w_hart_le, w_hart_ctrl, w_hart_lock,
    output w_dram_odata, w_dram_busy,
    input  w_hart_odata, w_hart_busy,
    input  w_dram_addr, w_dram_wdata, w_dram_we_t, w_dram_le, w_dram_ctrl, w_grant
  );
endinterface

// File: rtl/m_dram_arbiter_n.sv
// Round-robin N-hart arbiter onto a single DRAM controller port, with grant hold
// for locked (AMO) sequences and per-hart registered read data.
//
// state   | meaning
// S_IDLE  | choose next hart (lock owner first, else round-robin after rr_q)
// S_ISSUE | one-cycle downstream le/we_t strobe with the granted hart's fields
// S_WAIT  | skip one cycle, then wait for downstream busy low; capture read data
// S_DONE  | retire request, advance rr_q, sample lock of the granted hart
module m_dram_arbiter_n #(
  parameter int NHARTS = 2,
  parameter int AW     = 32,
  parameter int DW     = 32
) (
  input  logic CLK,
  input  logic RST_X,
  m_dram_arbiter_n_if.slave bus
);
  localparam int GW = (NHARTS > 1) ? $clog2(NHARTS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e                   state_q;
  logic [NHARTS-1:0]        pend_q;
  logic [NHARTS-1:0]        wr_q;
  logic [NHARTS-1:0][AW-1:0] addr_q;
  logic [NHARTS-1:0][DW-1:0] wdata_q;
  logic [NHARTS-1:0][2:0]   ctrl_q;
  logic [NHARTS-1:0][DW-1:0] odata_q;
  logic [GW-1:0]            grant_q;
  logic [GW-1:0]            rr_q;
  logic                     lock_valid_q;
  logic                     wait_first_q;
  logic [AW-1:0]            dram_addr_q;
  logic [DW-1:0]            dram_wdata_q;
  logic [2:0]               dram_ctrl_q;
  logic                     dram_le_q;
  logic                     dram_we_q;

  logic [NHARTS-1:0][AW-1:0] hart_addr;
  logic [NHARTS-1:0][DW-1:0] hart_wdata;
  logic [NHARTS-1:0][2:0]   hart_ctrl;

  assign hart_addr  = bus.w_hart_addr;
  assign hart_wdata = bus.w_hart_wdata;
  assign hart_ctrl  = bus.w_hart_ctrl;

  logic          pick_vld_d;
  logic [GW-1:0] pick_idx_d;
  logic [GW:0]   cand;

  // Scan from farthest to nearest so the hart right after rr_q wins.
  always_comb begin
    pick_vld_d = 1'b0;
    pick_idx_d = '0;
    cand       = '0;
    if (lock_valid_q) begin
      pick_vld_d = pend_q[rr_q];
      pick_idx_d = rr_q;
    end else begin
      for (int k = NHARTS; k >= 1; k--) begin
        cand = {1'b0, rr_q} + (GW+1)'(k);
        if (cand >= (GW+1)'(NHARTS)) cand = cand - (GW+1)'(NHARTS);
        if (pend_q[cand[GW-1:0]]) begin
          pick_vld_d = 1'b1;
          pick_idx_d = cand[GW-1:0];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state_q      <= S_IDLE;
      pend_q       <= '0;
      wr_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ctrl_q       <= '0;
      odata_q      <= '0;
      grant_q      <= '0;
      rr_q         <= GW'(NHARTS - 1);
      lock_valid_q <= 1'b0;
      wait_first_q <= 1'b0;
      dram_addr_q  <= '0;
      dram_wdata_q <= '0;
      dram_ctrl_q  <= '0;
      dram_le_q    <= 1'b0;
      dram_we_q    <= 1'b0;
    end else begin
      dram_le_q <= 1'b0;
      dram_we_q <= 1'b0;
      for (int i = 0; i < NHARTS; i++) begin
        if (!pend_q[i] && (bus.w_hart_le[i] || bus.w_hart_we_t[i])) begin
          pend_q[i]  <= 1'b1;
          wr_q[i]    <= bus.w_hart_we_t[i];
          addr_q[i]  <= hart_addr[i];
          wdata_q[i] <= hart_wdata[i];
          ctrl_q[i]  <= hart_ctrl[i];
        end
      end
      case (state_q)
        S_IDLE: begin
          if (pick_vld_d) begin
            grant_q      <= pick_idx_d;
            dram_addr_q  <= addr_q[pick_idx_d];
            dram_wdata_q <= wdata_q[pick_idx_d];
            dram_ctrl_q  <= ctrl_q[pick_idx_d];
            dram_le_q    <= !wr_q[pick_idx_d];
            dram_we_q    <= wr_q[pick_idx_d];
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_first_q <= 1'b1;
          state_q      <= S_WAIT;
        end
        S_WAIT: begin
          // Downstream busy only rises the cycle after the strobe.
          if (wait_first_q) begin
            wait_first_q <= 1'b0;
          end else if (!bus.w_dram_busy) begin
            if (!wr_q[grant_q]) odata_q[grant_q] <= bus.w_dram_odata;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          pend_q[grant_q] <= 1'b0;
          rr_q            <= grant_q;
          lock_valid_q    <= bus.w_hart_lock[grant_q];
          state_q         <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.w_hart_odata = odata_q;
  assign bus.w_hart_busy  = pend_q;
  assign bus.w_dram_addr  = dram_addr_q;
  assign bus.w_dram_wdata = dram_wdata_q;
  assign bus.w_dram_ctrl  = dram_ctrl_q;
  assign bus.w_dram_le    = dram_le_q;
  assign bus.w_dram_we_t  = dram_we_q;
  assign bus.w_grant      = grant_q;
endmodule

// File: tb/tb_m_dram_arbiter_n.sv
// Directed bench: a 2-hart arbiter for single/simultaneous/lock/reset cases and a
// 4-hart arbiter for continuous-request fairness, each behind a fixed-latency DRAM model.
module tb_m_dram_arbiter_n;
  logic CLK;
  logic RST_X;
  int   tests = 0;
  int   fails = 0;

  m_dram_arbiter_n_if #(.NHARTS(2), .AW(32), .DW(32)) bus2 ();
  m_dram_arbiter_n_if #(.NHARTS(4), .AW(32), .DW(32)) bus4 ();

  m_dram_arbiter_n #(.NHARTS(2), .AW(32), .DW(32)) u2 (.CLK(CLK), .RST_X(RST_X), .bus(bus2));
  m_dram_arbiter_n #(.NHARTS(4), .AW(32), .DW(32)) u4 (.CLK(CLK), .RST_X(RST_X), .bus(bus4));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // DRAM model: busy for 3 cycles after a strobe, read data = addr ^ 0x5EADBEEF.
  logic        m2_busy = 1'b0;
  logic [31:0] m2_odata = '0;
  logic [31:0] m2_raddr = '0;
  int          m2_cnt = 0;
  int          n_stb = 0;
  logic [31:0] log_addr[$];
  logic        log_we[$];
  logic [31:0] log_wd[$];

  always @(posedge CLK) begin
    if (bus2.w_dram_le || bus2.w_dram_we_t) begin
      m2_busy  <= 1'b1;
      m2_cnt   <= 3;
      m2_raddr <= bus2.w_dram_addr;
      n_stb    <= n_stb + 1;
      log_addr.push_back(bus2.w_dram_addr);
      log_we.push_back(bus2.w_dram_we_t);
      log_wd.push_back(bus2.w_dram_wdata);
    end else if (m2_busy) begin
      if (m2_cnt == 1) begin
        m2_busy  <= 1'b0;
        m2_odata <= m2_raddr ^ 32'h5EAD_BEEF;
      end
      m2_cnt <= m2_cnt - 1;
    end
  end
  assign bus2.w_dram_busy  = m2_busy;
  assign bus2.w_dram_odata = m2_odata;

  logic        m4_busy = 1'b0;
  int          m4_cnt = 0;
  logic [31:0] log4[$];

  always @(posedge CLK) begin
    if (bus4.w_dram_le || bus4.w_dram_we_t) begin
      m4_busy <= 1'b1;
      m4_cnt  <= 3;
      log4.push_back(bus4.w_dram_addr);
    end else if (m4_busy) begin
      if (m4_cnt == 1) m4_busy <= 1'b0;
      m4_cnt <= m4_cnt - 1;
    end
  end
  assign bus4.w_dram_busy  = m4_busy;
  assign bus4.w_dram_odata = 32'h0;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle2(output int n);
    n = 0;
    while (bus2.w_hart_busy != 2'b00 && n < 60) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int base;
    int stb0;
    int cnt[4];
    int last[4];
    int maxw;
    int seqerr;
    int h;
    logic [31:0] a;

    RST_X = 1'b0;
    bus2.w_hart_addr = '0; bus2.w_hart_wdata = '0; bus2.w_hart_we_t = '0;
    bus2.w_hart_le = '0; bus2.w_hart_ctrl = '0; bus2.w_hart_lock = '0;
    bus4.w_hart_addr = '0; bus4.w_hart_wdata = '0; bus4.w_hart_we_t = '0;
    bus4.w_hart_le = '0; bus4.w_hart_ctrl = '0; bus4.w_hart_lock = '0;
    tick();
    tick();
    chk("rst_busy", 64'(bus2.w_hart_busy), 64'h0);
    chk("rst_odata", 64'(bus2.w_hart_odata), 64'h0);
    chk("rst_strobes", 64'({bus2.w_dram_le, bus2.w_dram_we_t}), 64'h0);
    chk("rst_dram_addr", 64'(bus2.w_dram_addr), 64'h0);
    chk("rst_grant", 64'(bus2.w_grant), 64'h0);
    RST_X = 1'b1;
    tick();

    // Single read by hart0.
    bus2.w_hart_addr[31:0] = 32'h8000_0000;
    bus2.w_hart_ctrl[2:0]  = 3'b010;
    bus2.w_hart_le         = 2'b01;
    tick();
    bus2.w_hart_le = 2'b00;
    chk("rd_busy_rise", 64'(bus2.w_hart_busy), 64'h1);
    chk("rd_no_early_strobe", 64'(bus2.w_dram_le), 64'h0);
    tick();
    chk("rd_strobe", 64'(bus2.w_dram_le), 64'h1);
    chk("rd_addr", 64'(bus2.w_dram_addr), 64'h8000_0000);
    chk("rd_ctrl", 64'(bus2.w_dram_ctrl), 64'h2);
    chk("rd_grant", 64'(bus2.w_grant), 64'h0);
    tick();
    chk("rd_strobe_1cyc", 64'(bus2.w_dram_le), 64'h0);
    wait_idle2(n);
    chk("rd_latency", 64'(n), 64'd5);
    chk("rd_odata0", 64'(bus2.w_hart_odata[31:0]), 64'hDEAD_BEEF);
    chk("rd_odata1", 64'(bus2.w_hart_odata[63:32]), 64'h0);
    chk("rd_stb_count", 64'(n_stb), 64'd1);

    // Reset in the middle of WAIT.
    bus2.w_hart_addr[63:32] = 32'h0000_0300;
    bus2.w_hart_le = 2'b10;
    tick();
    bus2.w_hart_le = 2'b00;
    tick();
    tick();
    RST_X = 1'b0;
    tick();
    chk("mrst_busy", 64'(bus2.w_hart_busy), 64'h0);
    chk("mrst_odata", 64'(bus2.w_hart_odata), 64'h0);
    chk("mrst_strobe", 64'(bus2.w_dram_le), 64'h0);
    chk("mrst_grant", 64'(bus2.w_grant), 64'h0);
    RST_X = 1'b1;
    stb0 = n_stb;
    for (int i = 0; i < 6; i++) tick();
    chk("mrst_no_strobe", 64'(n_stb), 64'(stb0));
    chk("mrst_busy_after", 64'(bus2.w_hart_busy), 64'h0);
    chk("mrst_odata_after", 64'(bus2.w_hart_odata), 64'h0);

    // Simultaneous writes straight after reset: hart0 first, then hart1.
    base = log_addr.size();
    bus2.w_hart_addr  = {32'h0000_0200, 32'h0000_0100};
    bus2.w_hart_wdata = {32'h0000_BBBB, 32'h0000_AAAA};
    bus2.w_hart_we_t  = 2'b11;
    tick();
    bus2.w_hart_we_t = 2'b00;
    chk("sim_busy_both", 64'(bus2.w_hart_busy), 64'h3);
    wait_idle2(n);
    chk("sim_done", 64'(n < 60), 64'h1);
    chk("sim_cnt", 64'(log_addr.size() - base), 64'd2);
    chk("sim_first", 64'(log_addr[base]), 64'h100);
    chk("sim_second", 64'(log_addr[base+1]), 64'h200);
    chk("sim_wdata0", 64'(log_wd[base]), 64'hAAAA);
    chk("sim_wdata1", 64'(log_wd[base+1]), 64'hBBBB);
    chk("sim_we", 64'({log_we[base], log_we[base+1]}), 64'h3);
    chk("sim_odata_kept", 64'(bus2.w_hart_odata), 64'h0);

    // Second pair: hart1 was served last, so hart0 leads again.
    base = log_addr.size();
    bus2.w_hart_addr = {32'h0000_0220, 32'h0000_0120};
    bus2.w_hart_we_t = 2'b11;
    tick();
    bus2.w_hart_we_t = 2'b00;
    wait_idle2(n);
    chk("sim2_first", 64'(log_addr[base]), 64'h120);
    chk("sim2_second", 64'(log_addr[base+1]), 64'h220);

    // Lock: hart1 locked read, hart0 waits, hart1 unlocking write, then hart0.
    base = log_addr.size();
    bus2.w_hart_lock = 2'b10;
    bus2.w_hart_addr[63:32] = 32'h0000_0400;
    bus2.w_hart_le = 2'b10;
    tick();
    bus2.w_hart_addr[31:0] = 32'h0000_0500;
    bus2.w_hart_le = 2'b01;
    tick();
    bus2.w_hart_le = 2'b00;
    n = 0;
    while (bus2.w_hart_busy[1] && n < 60) begin
      tick();
      n++;
    end
    chk("lock_rd_done", 64'(n < 60), 64'h1);
    chk("lock_hart0_pending", 64'(bus2.w_hart_busy), 64'h1);
    chk("lock_rd_odata1", 64'(bus2.w_hart_odata[63:32]), 64'h5EAD_BAEF);
    bus2.w_hart_lock = 2'b00;
    stb0 = n_stb;
    for (int i = 0; i < 4; i++) tick();
    chk("lock_hold_no_strobe", 64'(n_stb), 64'(stb0));
    chk("lock_hold_busy", 64'(bus2.w_hart_busy), 64'h1);
    chk("lock_hold_grant", 64'(bus2.w_grant), 64'h1);
    bus2.w_hart_addr[63:32]  = 32'h0000_0404;
    bus2.w_hart_wdata[63:32] = 32'h0000_0077;
    bus2.w_hart_we_t = 2'b10;
    tick();
    bus2.w_hart_we_t = 2'b00;
    wait_idle2(n);
    chk("lock_all_done", 64'(n < 60), 64'h1);
    chk("lock_cnt", 64'(log_addr.size() - base), 64'd3);
    chk("lock_order0", 64'({log_addr[base], 31'h0, log_we[base]}), 64'h0000_0400_0000_0000);
    chk("lock_order1", 64'({log_addr[base+1], 31'h0, log_we[base+1]}), 64'h0000_0404_0000_0001);
    chk("lock_order2", 64'({log_addr[base+2], 31'h0, log_we[base+2]}), 64'h0000_0500_0000_0000);
    chk("lock_odata", 64'(bus2.w_hart_odata), 64'h5EAD_BAEF_5EAD_BBEF);

    // Four harts requesting continuously.
    bus4.w_hart_addr = {32'h30, 32'h20, 32'h10, 32'h00};
    bus4.w_hart_le   = 4'hF;
    n = 0;
    while (log4.size() < 400 && n < 20000) begin
      tick();
      n++;
    end
    bus4.w_hart_le = 4'h0;
    chk("fair_budget", 64'(n < 20000), 64'h1);
    n = 0;
    while (bus4.w_hart_busy != 4'h0 && n < 100) begin
      tick();
      n++;
    end
    chk("fair_drain", 64'(n < 100), 64'h1);
    seqerr = 0;
    maxw = 0;
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0;
      last[i] = -1;
    end
    for (int k = 0; k < 400 && k < log4.size(); k++) begin
      a = log4[k];
      h = int'(a[5:4]);
      if (h != k % 4) seqerr++;
      cnt[h]++;
      if (last[h] >= 0 && (k - last[h] - 1) > maxw) maxw = k - last[h] - 1;
      last[h] = k;
    end
    chk("fair_rr_order", 64'(seqerr), 64'd0);
    chk("fair_cnt0", 64'(cnt[0]), 64'd100);
    chk("fair_cnt1", 64'(cnt[1]), 64'd100);
    chk("fair_cnt2", 64'(cnt[2]), 64'd100);
    chk("fair_cnt3", 64'(cnt[3]), 64'd100);
    chk("fair_max_wait", 64'(maxw), 64'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
